// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter.
// Runs power-up init ownership, then grants the shared command/address/bank
// bus to auto-refresh (fixed top priority), write and read (round-robin).
// A per-grant watchdog returns the bus to ARBIT if an owner never finishes.
//
// Ports:
//   sclk, s_rst                 clock, asynchronous active-high reset
//   flag_init_end               init sequence finished
//   init_cmd/init_addr          init module bus
//   ref_req/flag_ref_end        refresh request / done pulse
//   ref_cmd/ref_addr            refresh module bus
//   wr_req/rd_req               write / read requests (held until grant)
//   flag_wr_end/flag_rd_end     burst done pulses
//   wr_cmd/wr_addr/wr_bank      write module bus
//   rd_cmd/rd_addr/rd_bank      read module bus
//   ref_en/wr_en/rd_en          1-cycle grant pulses
//   sd_cmd/sd_addr/sd_bank      SDRAM pin buses
//   dq_oe                       data-bus output enable (WRITE only)
//   tmo_err                     1-cycle watchdog expiry pulse
//   cur_state                   one-hot state for debug
module sdram_arbit #(
   parameter int unsigned TMO     = 1023,
   parameter logic [3:0]  NOP_CMD = 4'b0111
) (
   input  logic        sclk,
   input  logic        s_rst,
   input  logic        flag_init_end,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        ref_req,
   input  logic        flag_ref_end,
   input  logic [3:0]  ref_cmd,
   input  logic [11:0] ref_addr,
   input  logic        wr_req,
   input  logic        rd_req,
   input  logic        flag_wr_end,
   input  logic        flag_rd_end,
   input  logic [3:0]  wr_cmd,
   input  logic [11:0] wr_addr,
   input  logic [1:0]  wr_bank,
   input  logic [3:0]  rd_cmd,
   input  logic [11:0] rd_addr,
   input  logic [1:0]  rd_bank,
   output logic        ref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic [3:0]  sd_cmd,
   output logic [11:0] sd_addr,
   output logic [1:0]  sd_bank,
   output logic        dq_oe,
   output logic        tmo_err,
   output logic [4:0]  cur_state
);

   localparam int unsigned WDT_W = 16;

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      ARBIT = 5'b00010,
      AREF  = 5'b00100,
      WRITE = 5'b01000,
      READ  = 5'b10000
   } state_t;

   state_t           state, state_nxt;
   logic             last_rd, last_rd_nxt;     // 1: read was granted last
   logic [WDT_W-1:0] wdt, wdt_nxt;
   logic             ref_en_nxt, wr_en_nxt, rd_en_nxt, tmo_err_nxt;
   logic             wdt_exp;

   // Expiry fires on the edge where the counter would reach TMO
   assign wdt_exp = (wdt == WDT_W'(TMO - 1));

   // State and registered pulse outputs
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state   <= IDLE;
         last_rd <= 1'b1;
         wdt     <= '0;
         ref_en  <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         tmo_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         last_rd <= last_rd_nxt;
         wdt     <= wdt_nxt;
         ref_en  <= ref_en_nxt;
         wr_en   <= wr_en_nxt;
         rd_en   <= rd_en_nxt;
         tmo_err <= tmo_err_nxt;
      end
   end

   // Next-state, grant and watchdog logic
   always_comb begin
      state_nxt   = state;
      last_rd_nxt = last_rd;
      wdt_nxt     = wdt;
      ref_en_nxt  = 1'b0;
      wr_en_nxt   = 1'b0;
      rd_en_nxt   = 1'b0;
      tmo_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (flag_init_end) state_nxt = ARBIT;
         end
         ARBIT: begin
            if (ref_req) begin
               state_nxt  = AREF;
               ref_en_nxt = 1'b1;
               wdt_nxt    = '0;
            end else if (wr_req && (!rd_req || last_rd)) begin
               state_nxt   = WRITE;
               wr_en_nxt   = 1'b1;
               last_rd_nxt = 1'b0;
               wdt_nxt     = '0;
            end else if (rd_req) begin
               state_nxt   = READ;
               rd_en_nxt   = 1'b1;
               last_rd_nxt = 1'b1;
               wdt_nxt     = '0;
            end
         end
         AREF: begin
            wdt_nxt = wdt + 1'b1;
            if (flag_ref_end) begin
               state_nxt = ARBIT;
            end else if (wdt_exp) begin
               state_nxt   = ARBIT;
               tmo_err_nxt = 1'b1;
            end
         end
         WRITE: begin
            wdt_nxt = wdt + 1'b1;
            if (flag_wr_end) begin
               state_nxt = ARBIT;
            end else if (wdt_exp) begin
               state_nxt   = ARBIT;
               tmo_err_nxt = 1'b1;
            end
         end
         READ: begin
            wdt_nxt = wdt + 1'b1;
            if (flag_rd_end) begin
               state_nxt = ARBIT;
            end else if (wdt_exp) begin
               state_nxt   = ARBIT;
               tmo_err_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pin mux follows the registered owner so reset drops to init at once
   always_comb begin
      sd_cmd  = NOP_CMD;
      sd_addr = '0;
      sd_bank = '0;
      case (state)
         IDLE: begin
            sd_cmd  = init_cmd;
            sd_addr = init_addr;
         end
         AREF: begin
            sd_cmd  = ref_cmd;
            sd_addr = ref_addr;
         end
         WRITE: begin
            sd_cmd  = wr_cmd;
            sd_addr = wr_addr;
            sd_bank = wr_bank;
         end
         READ: begin
            sd_cmd  = rd_cmd;
            sd_addr = rd_addr;
            sd_bank = rd_bank;
         end
         default: ;
      endcase
   end

   assign dq_oe     = (state == WRITE);
   assign cur_state = state;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Standalone command arbiter for the SDRAM controller. It sequences power-up initialisation, then shares the single SDRAM command/address/bank/data bus among three requesters: auto-refresh, write and read. Refresh has fixed top priority. Write and read alternate round-robin. A per-grant watchdog recovers the bus if a requester never signals completion. It sits between the init/aref/write/read sub-modules and the SDRAM pins, and drives the pin-level command and address buses.

## Interface
- TMO, 1023: watchdog limit in sclk cycles per grant (1..65535).
- NOP_CMD, 4'b0111: {cs_n,ras_n,cas_n,we_n} driven when no module owns the bus.

- sclk  in  1  system clock.
- s_rst  in  1  asynchronous, active-high reset.
- flag_init_end  in  1  init module finished (level or pulse).
- init_cmd / init_addr  in  4 / 12  init module command and address.
- ref_req  in  1  refresh request, held until ref_en.
- flag_ref_end  in  1  refresh done, 1-cycle pulse.
- ref_cmd / ref_addr  in  4 / 12  refresh command and address.
- wr_req, rd_req  in  1 each  write / read request, held until grant.
- flag_wr_end, flag_rd_end  in  1 each  burst done, 1-cycle pulse.
- wr_cmd / wr_addr / wr_bank  in  4 / 12 / 2  write module bus.
- rd_cmd / rd_addr / rd_bank  in  4 / 12 / 2  read module bus.
- ref_en, wr_en, rd_en  out  1 each  grant pulse, 1 cycle.
- sd_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins.
- sd_addr  out  12  SDRAM address.
- sd_bank  out  2  SDRAM bank.
- dq_oe  out  1  data-bus output enable (1 only while in WRITE).
- tmo_err  out  1  1-cycle pulse on watchdog expiry.
- cur_state  out  5  one-hot state, for debug.

## Operation
- States (one-hot): IDLE=00001, ARBIT=00010, AREF=00100, WRITE=01000, READ=10000.
- IDLE: bus owned by init. Goes to ARBIT on flag_init_end=1. Never re-entered except through reset.
- ARBIT: bus drives NOP_CMD, address 0, bank 0. Decision is made on the same edge:
  - ref_req=1 goes to AREF and pulses ref_en. Wins regardless of other requests.
  - Else wr_req and rd_req both 1: grant the one not granted last (last_gnt register), pulse wr_en or rd_en, go to WRITE or READ, update last_gnt.
  - Else a single wr_req or rd_req is granted directly, and last_gnt is updated.
  - No request: stay in ARBIT.
- AREF, WRITE and READ each return to ARBIT on their own end flag. End flags from non-owning modules are ignored.
- Watchdog:
  - A 16-bit counter clears on every grant and increments each cycle in AREF/WRITE/READ.
  - If it reaches TMO with no end flag, go to ARBIT and pulse tmo_err.
  - An end flag in the same cycle as expiry takes precedence, so no tmo_err.
- Output mux (combinational from registered state):
  - IDLE selects init_cmd/init_addr.
  - AREF selects ref_cmd/ref_addr.
  - WRITE selects wr_cmd/wr_addr/wr_bank.
  - READ selects rd_cmd/rd_addr/rd_bank.
  - ARBIT or an illegal state drives NOP_CMD, 0, 0.
  - sd_bank is 0 outside WRITE/READ.
- Illegal state encoding goes to IDLE on the next edge.

## Timing
- Reset values:
  - state=IDLE.
  - ref_en=wr_en=rd_en=0, tmo_err=0.
  - last_gnt=READ, so write wins the first tie.
  - watchdog=0, dq_oe=0.
  - sd_cmd/sd_addr follow init_cmd/init_addr.
- Grant latency: a request sampled at edge N in ARBIT gives state change and en pulse at edge N. The module owns the bus from cycle N+1.
- End to next grant: end flag at edge M gives ARBIT for at least one cycle (cycle M+1). The earliest next grant is edge M+1. There are no back-to-back grants without an ARBIT cycle.
- Requesters hold req until they see en. The arbiter does not latch requests.
- Reset asserted mid-burst: all outputs return to reset values asynchronously and the bus drops to init ownership immediately. Bursts are not resumed.

## Test plan
- Reset, then flag_init_end pulse at cycle 10 -> state=ARBIT at cycle 11, sd_cmd=4'b0111, sd_addr=0, all en=0.
- ref_req, wr_req and rd_req all high in ARBIT -> ref_en pulse and AREF. After flag_ref_end: wr_en (last_gnt reset=READ), then rd_en on the next arbitration.
- wr_req and rd_req held continuously, end flags 8 cycles after each grant -> grants alternate W,R,W,R. Each grant is separated by exactly one ARBIT cycle.
- In WRITE with wr_cmd=4'b0100, wr_addr=12'h155, wr_bank=2'b10 -> sd_cmd, sd_addr and sd_bank match and dq_oe=1. dq_oe=0 in the cycle after flag_wr_end.
- TMO=20, grant read and never pulse flag_rd_end -> tmo_err pulse 20 cycles after rd_en, state=ARBIT on the next cycle. A repeat with flag_rd_end on the expiry cycle -> no tmo_err.
- s_rst asserted mid-WRITE -> state=IDLE and dq_oe=0 without a clock edge. After release, operation requires flag_init_end again.
